// File: rtl/reducer_accumulator.sv
// Reducer-side per-cluster store: sweeps entries to zero, then accumulates point vectors and point
// counts, and serves both to the merger through two independent one-cycle-latency read ports.
module reducer_accumulator #(
  parameter int CENTRE_WIDTH = 32,
  parameter int SUM_WIDTH    = 64,
  parameter int DIMENSION    = 4,
  parameter int BRAM_BITS    = 3
) (
  input  logic                              clock,
  input  logic                              reset_n,
  input  logic                              i_clear,
  input  logic                              i_pt_valid,
  output logic                              o_pt_ready,
  input  logic [BRAM_BITS-1:0]              i_pt_cluster,
  input  logic [CENTRE_WIDTH*DIMENSION-1:0] i_pt_data,
  input  logic                              i_pt_last,
  output logic                              o_acc_done,
  input  logic                              i_ce_sum,
  input  logic [BRAM_BITS-1:0]              i_sum_address,
  output logic [SUM_WIDTH*DIMENSION-1:0]    o_sum_pts,
  input  logic                              i_ce_counter,
  input  logic [BRAM_BITS-1:0]              i_counter_address,
  output logic [31:0]                       o_count_pts
);

  localparam int DEPTH = 2 ** BRAM_BITS;
  localparam logic [BRAM_BITS-1:0] LAST_IDX = BRAM_BITS'(DEPTH - 1);

  typedef enum logic [1:0] {
    S_CLEAR = 2'd0,
    S_ACCUM = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t                                        state_q;
  logic [BRAM_BITS-1:0]                          idx_q;
  logic                                          ready_q;
  logic                                          done_q;
  logic [DEPTH-1:0][DIMENSION-1:0][SUM_WIDTH-1:0] sum_q;
  logic [DEPTH-1:0][31:0]                        count_q;
  logic                                          accept_s;

  function automatic logic [SUM_WIDTH-1:0] sext(input logic [CENTRE_WIDTH-1:0] x);
    return {{(SUM_WIDTH - CENTRE_WIDTH){x[CENTRE_WIDTH-1]}}, x};
  endfunction

  function automatic logic [31:0] sat_inc(input logic [31:0] c);
    return (c == 32'hFFFF_FFFF) ? c : c + 32'd1;
  endfunction

  // A clear request in the same cycle always beats a presented point.
  assign accept_s   = ready_q & i_pt_valid & ~i_clear;
  assign o_pt_ready = ready_q;
  assign o_acc_done = done_q;

  // Control FSM with registered ready/done decodes of the next state
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_CLEAR;
      idx_q   <= '0;
      ready_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        S_CLEAR: begin
          done_q <= 1'b0;
          if (i_clear) begin
            idx_q   <= '0;
            ready_q <= 1'b0;
          end else if (idx_q == LAST_IDX) begin
            idx_q   <= '0;
            state_q <= S_ACCUM;
            ready_q <= 1'b1;
          end else begin
            idx_q   <= idx_q + 1'b1;
            ready_q <= 1'b0;
          end
        end
        S_ACCUM: begin
          if (i_clear) begin
            state_q <= S_CLEAR;
            idx_q   <= '0;
            ready_q <= 1'b0;
            done_q  <= 1'b0;
          end else if (accept_s && i_pt_last) begin
            state_q <= S_DONE;
            ready_q <= 1'b0;
            done_q  <= 1'b1;
          end else begin
            ready_q <= 1'b1;
            done_q  <= 1'b0;
          end
        end
        S_DONE: begin
          ready_q <= 1'b0;
          if (i_clear) begin
            state_q <= S_CLEAR;
            idx_q   <= '0;
            done_q  <= 1'b0;
          end else begin
            done_q  <= 1'b1;
          end
        end
        default: begin
          state_q <= S_CLEAR;
          idx_q   <= '0;
          ready_q <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  // Entry storage: zeroing sweep or single-cycle read-modify-write of one cluster
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sum_q   <= '0;
      count_q <= '0;
    end else if (state_q == S_CLEAR) begin
      sum_q[idx_q]   <= '0;
      count_q[idx_q] <= 32'd0;
    end else if (accept_s) begin
      for (int d = 0; d < DIMENSION; d++) begin
        sum_q[i_pt_cluster][d] <= sum_q[i_pt_cluster][d]
                                  + sext(i_pt_data[d*CENTRE_WIDTH +: CENTRE_WIDTH]);
      end
      count_q[i_pt_cluster] <= sat_inc(count_q[i_pt_cluster]);
    end
  end

  // Merger read ports; registered so data lines up with the merger's registered ce mux
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      o_sum_pts   <= '0;
      o_count_pts <= 32'd0;
    end else begin
      if (i_ce_sum) begin
        o_sum_pts <= sum_q[i_sum_address];
      end
      if (i_ce_counter) begin
        o_count_pts <= count_q[i_counter_address];
      end
    end
  end

endmodule

// File: tb/tb_reducer_accumulator.sv
// Self-checking bench for reducer_accumulator against a plain-arithmetic per-cluster model.
module tb_reducer_accumulator;

  localparam int CW    = 32;
  localparam int SW    = 64;
  localparam int DIM   = 4;
  localparam int BB    = 3;
  localparam int DEPTH = 8;

  logic              clock = 1'b0;
  logic              reset_n;
  logic              i_clear;
  logic              i_pt_valid;
  logic              o_pt_ready;
  logic [BB-1:0]     i_pt_cluster;
  logic [CW*DIM-1:0] i_pt_data;
  logic              i_pt_last;
  logic              o_acc_done;
  logic              i_ce_sum;
  logic [BB-1:0]     i_sum_address;
  logic [SW*DIM-1:0] o_sum_pts;
  logic              i_ce_counter;
  logic [BB-1:0]     i_counter_address;
  logic [31:0]       o_count_pts;

  int errors = 0;
  int checks = 0;

  longint sum_m[DEPTH][DIM];
  longint count_m[DEPTH];

  always #5 clock = ~clock;

  reducer_accumulator #(
    .CENTRE_WIDTH(CW), .SUM_WIDTH(SW), .DIMENSION(DIM), .BRAM_BITS(BB)
  ) dut (
    .clock(clock), .reset_n(reset_n), .i_clear(i_clear),
    .i_pt_valid(i_pt_valid), .o_pt_ready(o_pt_ready), .i_pt_cluster(i_pt_cluster),
    .i_pt_data(i_pt_data), .i_pt_last(i_pt_last), .o_acc_done(o_acc_done),
    .i_ce_sum(i_ce_sum), .i_sum_address(i_sum_address), .o_sum_pts(o_sum_pts),
    .i_ce_counter(i_ce_counter), .i_counter_address(i_counter_address),
    .o_count_pts(o_count_pts)
  );

  function automatic logic [CW*DIM-1:0] pack4(input int a0, input int a1, input int a2, input int a3);
    return {a3, a2, a1, a0};
  endfunction

  function automatic logic [SW*DIM-1:0] exp_sum(input int c);
    logic [SW*DIM-1:0] v;
    for (int d = 0; d < DIM; d++) v[d*SW +: SW] = sum_m[c][d];
    return v;
  endfunction

  task automatic model_clear();
    for (int c = 0; c < DEPTH; c++) begin
      count_m[c] = 0;
      for (int d = 0; d < DIM; d++) sum_m[c][d] = 0;
    end
  endtask

  task automatic model_add(input int c, input logic [CW*DIM-1:0] data);
    int coord;
    for (int d = 0; d < DIM; d++) begin
      coord = data[d*CW +: CW];
      sum_m[c][d] = sum_m[c][d] + longint'(coord);
    end
    if (count_m[c] < 64'sd4294967295) count_m[c] = count_m[c] + 1;
  endtask

  // Drives one point for one clock; the caller guarantees the block is accepting.
  task automatic send_point(input int c, input logic [CW*DIM-1:0] data, input logic last);
    i_pt_valid   = 1'b1;
    i_pt_cluster = BB'(c);
    i_pt_data    = data;
    i_pt_last    = last;
    @(posedge clock);
    @(negedge clock);
    i_pt_valid = 1'b0;
    i_pt_last  = 1'b0;
    model_add(c, data);
  endtask

  task automatic read_entry(input int a, output logic [SW*DIM-1:0] s, output logic [31:0] c);
    i_ce_sum          = 1'b1;
    i_ce_counter      = 1'b1;
    i_sum_address     = BB'(a);
    i_counter_address = BB'(a);
    @(posedge clock);
    @(negedge clock);
    s = o_sum_pts;
    c = o_count_pts;
    i_ce_sum     = 1'b0;
    i_ce_counter = 1'b0;
  endtask

  task automatic wait_ready(output int n);
    n = 0;
    while (!o_pt_ready && n < 50) begin
      @(posedge clock);
      @(negedge clock);
      n++;
    end
  endtask

  task automatic test_reset();
    logic [SW*DIM-1:0] s;
    logic [31:0] c;
    int n;
    #1;
    checks++;
    if ({o_pt_ready, o_acc_done, o_sum_pts, o_count_pts} !== '0) begin
      errors++; $display("FAIL reset_outputs: got rdy=%b done=%b cnt=%h expected all zero", o_pt_ready, o_acc_done, o_count_pts);
    end
    @(negedge clock);
    reset_n = 1'b1;
    wait_ready(n);
    checks++;
    if (n != DEPTH) begin
      errors++; $display("FAIL reset_sweep_len: got %0d cycles expected %0d", n, DEPTH);
    end
    model_clear();
    for (int a = 0; a < DEPTH; a++) begin
      read_entry(a, s, c);
      checks++;
      if (s !== exp_sum(a) || c !== 32'(count_m[a])) begin
        errors++; $display("FAIL reset_entry%0d: got sum=%h cnt=%h expected zero", a, s, c);
      end
    end
  endtask

  task automatic test_accumulate();
    logic [SW*DIM-1:0] s;
    logic [31:0] c;
    send_point(2, pack4(1, 2, 3, 4), 1'b0);
    send_point(2, pack4(-1, 5, 0, 10), 1'b0);
    send_point(5, pack4(7, 7, 7, 7), 1'b1);
    checks++;
    if (o_acc_done !== 1'b1 || o_pt_ready !== 1'b0) begin
      errors++; $display("FAIL acc_done: got done=%b rdy=%b expected done=1 rdy=0", o_acc_done, o_pt_ready);
    end
    read_entry(2, s, c);
    checks++;
    if (s !== {64'd14, 64'd3, 64'd7, 64'd0} || c !== 32'd2) begin
      errors++; $display("FAIL acc_entry2: got sum=%h cnt=%0d expected sums {0,7,3,14} cnt 2", s, c);
    end
    read_entry(5, s, c);
    checks++;
    if (s !== exp_sum(5) || c !== 32'd1) begin
      errors++; $display("FAIL acc_entry5: got sum=%h cnt=%0d expected %h cnt 1", s, c, exp_sum(5));
    end
    // Address moves while ce is low: output must hold entry 5.
    i_sum_address     = 3'd2;
    i_counter_address = 3'd2;
    @(posedge clock);
    @(negedge clock);
    checks++;
    if (o_sum_pts !== exp_sum(5) || o_count_pts !== 32'd1) begin
      errors++; $display("FAIL read_hold: got sum=%h cnt=%0d expected %h cnt 1", o_sum_pts, o_count_pts, exp_sum(5));
    end
    checks++;
    if (o_acc_done !== 1'b1) begin
      errors++; $display("FAIL done_frozen: got %b expected 1", o_acc_done);
    end
  endtask

  task automatic do_clear();
    int n;
    i_clear = 1'b1;
    @(posedge clock);
    @(negedge clock);
    i_clear = 1'b0;
    checks++;
    if (o_acc_done !== 1'b0 || o_pt_ready !== 1'b0) begin
      errors++; $display("FAIL clear_start: got done=%b rdy=%b expected 0 0", o_acc_done, o_pt_ready);
    end
    wait_ready(n);
    checks++;
    if (n != DEPTH) begin
      errors++; $display("FAIL clear_sweep_len: got %0d expected %0d", n, DEPTH);
    end
    model_clear();
  endtask

  task automatic test_sign_extension();
    logic [SW*DIM-1:0] s;
    logic [31:0] c;
    do_clear();
    send_point(0, pack4(32'h8000_0000, -3, 32'h7FFF_FFFF, 9), 1'b0);
    read_entry(0, s, c);
    checks++;
    if (s[SW-1:0] !== 64'hFFFF_FFFF_8000_0000) begin
      errors++; $display("FAIL sext_d0: got %h expected ffffffff80000000", s[SW-1:0]);
    end
    checks++;
    if (s !== exp_sum(0) || c !== 32'd1) begin
      errors++; $display("FAIL sext_entry0: got sum=%h cnt=%0d expected %h cnt 1", s, c, exp_sum(0));
    end
  endtask

  task automatic test_clear_drop();
    logic [SW*DIM-1:0] s;
    logic [31:0] c;
    int n;
    i_pt_valid   = 1'b1;
    i_pt_cluster = 3'd3;
    i_pt_data    = pack4(11, 12, 13, 14);
    i_clear      = 1'b1;
    @(posedge clock);
    @(negedge clock);
    i_pt_valid = 1'b0;
    i_clear    = 1'b0;
    wait_ready(n);
    checks++;
    if (n != DEPTH) begin
      errors++; $display("FAIL drop_sweep_len: got %0d expected %0d", n, DEPTH);
    end
    model_clear();
    for (int a = 0; a < DEPTH; a++) begin
      read_entry(a, s, c);
      checks++;
      if (s !== exp_sum(a) || c !== 32'(count_m[a])) begin
        errors++; $display("FAIL drop_entry%0d: got sum=%h cnt=%h expected zero", a, s, c);
      end
    end
  endtask

  task automatic test_saturation();
    logic [SW*DIM-1:0] s;
    logic [31:0] c;
    logic [DEPTH*32-1:0] preload;
    preload        = '0;
    preload[63:32] = 32'hFFFF_FFFE;
    force dut.count_q = preload;
    @(posedge clock);
    @(negedge clock);
    release dut.count_q;
    count_m[1] = 64'sd4294967294;
    for (int i = 0; i < 3; i++) send_point(1, pack4(i + 1, -i, 100, -100), 1'b0);
    read_entry(1, s, c);
    checks++;
    if (c !== 32'hFFFF_FFFF || c !== 32'(count_m[1])) begin
      errors++; $display("FAIL sat_count: got %h expected ffffffff", c);
    end
    checks++;
    if (s !== exp_sum(1)) begin
      errors++; $display("FAIL sat_sum: got %h expected %h", s, exp_sum(1));
    end
  endtask

  task automatic test_random();
    logic [SW*DIM-1:0] s;
    logic [31:0] c;
    logic [SW*DIM-1:0] es;
    logic [31:0] ec;
    logic [CW*DIM-1:0] data;
    int cl, ra;
    do_clear();
    for (int i = 0; i < 80; i++) begin
      ra = $urandom_range(DEPTH - 1, 0);
      es = exp_sum(ra);
      ec = 32'(count_m[ra]);
      i_ce_sum          = 1'b1;
      i_ce_counter      = 1'b1;
      i_sum_address     = BB'(ra);
      i_counter_address = BB'(ra);
      if ($urandom_range(3, 0) != 0) begin
        cl   = (i % 3 == 0) ? ra : $urandom_range(DEPTH - 1, 0);
        data = {$urandom, $urandom, $urandom, $urandom};
        send_point(cl, data, 1'b0);
      end else begin
        @(posedge clock);
        @(negedge clock);
      end
      i_ce_sum     = 1'b0;
      i_ce_counter = 1'b0;
      if (i % 8 == 7) begin
        checks++;
        if (o_sum_pts !== es || o_count_pts !== ec) begin
          errors++; $display("FAIL rand_read%0d: got sum=%h cnt=%h expected %h %h", i, o_sum_pts, o_count_pts, es, ec);
        end
      end else if (o_sum_pts !== es || o_count_pts !== ec) begin
        checks++;
        errors++; $display("FAIL rand_read%0d: got sum=%h cnt=%h expected %h %h", i, o_sum_pts, o_count_pts, es, ec);
      end else begin
        checks++;
      end
    end
    send_point(6, {$urandom, $urandom, $urandom, $urandom}, 1'b1);
    checks++;
    if (o_acc_done !== 1'b1) begin
      errors++; $display("FAIL rand_done: got %b expected 1", o_acc_done);
    end
    for (int a = 0; a < DEPTH; a++) begin
      read_entry(a, s, c);
      checks++;
      if (s !== exp_sum(a) || c !== 32'(count_m[a])) begin
        errors++; $display("FAIL rand_entry%0d: got sum=%h cnt=%h expected %h %h", a, s, c, exp_sum(a), 32'(count_m[a]));
      end
    end
  endtask

  task automatic test_async_reset();
    logic [SW*DIM-1:0] s;
    logic [31:0] c;
    int n;
    do_clear();
    send_point(4, pack4(5, 6, 7, 8), 1'b0);
    read_entry(4, s, c);
    checks++;
    if (c !== 32'd1 || o_pt_ready !== 1'b1) begin
      errors++; $display("FAIL arst_pre: got cnt=%0d rdy=%b expected 1 1", c, o_pt_ready);
    end
    #2;
    reset_n = 1'b0;
    #1;
    checks++;
    if ({o_pt_ready, o_acc_done, o_sum_pts, o_count_pts} !== '0) begin
      errors++; $display("FAIL arst_outputs: got rdy=%b cnt=%h sum=%h expected zero", o_pt_ready, o_count_pts, o_sum_pts);
    end
    @(negedge clock);
    reset_n = 1'b1;
    wait_ready(n);
    checks++;
    if (n != DEPTH) begin
      errors++; $display("FAIL arst_sweep_len: got %0d expected %0d", n, DEPTH);
    end
    model_clear();
    read_entry(4, s, c);
    checks++;
    if (s !== exp_sum(4) || c !== 32'd0) begin
      errors++; $display("FAIL arst_entry4: got sum=%h cnt=%h expected zero", s, c);
    end
  endtask

  initial begin
    reset_n           = 1'b0;
    i_clear           = 1'b0;
    i_pt_valid        = 1'b0;
    i_pt_cluster      = '0;
    i_pt_data         = '0;
    i_pt_last         = 1'b0;
    i_ce_sum          = 1'b0;
    i_sum_address     = '0;
    i_ce_counter      = 1'b0;
    i_counter_address = '0;
    model_clear();
    test_reset();
    test_accumulate();
    test_sign_extension();
    test_clear_drop();
    test_saturation();
    test_random();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
